// File: rtl/lane_merging_mx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lane_merging_mx: packs 1/2/4 aligned byte lanes into OUT_BYTES words      |
// | with a one-word hold stage so the final word of a burst carries pkt_eof.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lane_merging_mx #(
  parameter int MAX_LANES = 4,
  parameter int OUT_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             lane_num,
  input  logic                   align_lane_vld,
  input  logic [8*MAX_LANES-1:0] lane_data,
  output logic [8*OUT_BYTES-1:0] merging_dat,
  output logic [OUT_BYTES-1:0]   merging_be,
  output logic                   merging_valid,
  output logic                   pkt_sof,
  output logic                   pkt_eof,
  output logic                   cfg_err,
  output logic                   gap_err
);

  localparam int FILL_W = $clog2(OUT_BYTES) + 1;
  localparam int DW     = 8 * OUT_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MERGE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                prev_vld_q, prev_vld_d;
  logic [2:0]          n_q, n_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [DW-1:0]       acc_q, acc_d;
  logic [DW-1:0]       hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic                sof_pend_q, sof_pend_d;
  logic [DW-1:0]       dat_q, dat_d;
  logic [OUT_BYTES-1:0] be_q, be_d;
  logic                valid_q, valid_d;
  logic                sof_q, sof_d;
  logic                eof_q, eof_d;
  logic                cfg_err_q, cfg_err_d;
  logic                gap_err_q, gap_err_d;

  logic                lane_legal;
  logic [2:0]          n_eff;
  logic [DW-1:0]       acc_app;
  logic [FILL_W-1:0]   fill_app;
  logic                word_done;
  logic [OUT_BYTES-1:0] partial_be;
  logic                has_partial;
  logic                do_append;
  int                  n_int;
  int                  f_int;
  int                  fill_sum;

  assign lane_legal  = ((lane_num == 3'd1) || (lane_num == 3'd2) || (lane_num == 3'd4)) &&
                       (int'(lane_num) <= MAX_LANES);
  // In IDLE the burst-start cycle is merged with the lane count being latched now.
  assign n_eff       = (state_q == ST_IDLE) ? lane_num : n_q;
  assign has_partial = (fill_q != '0);

  always_comb begin
    n_int      = int'(n_eff);
    f_int      = int'(fill_q);
    acc_app    = acc_q;
    partial_be = '0;
    for (int b = 0; b < OUT_BYTES; b++) begin
      for (int l = 0; l < MAX_LANES; l++) begin
        if ((l < n_int) && (f_int + l == b)) begin
          acc_app[8*b +: 8] = lane_data[8*l +: 8];
        end
      end
      if (b < f_int) begin
        partial_be[b] = 1'b1;
      end
    end
    fill_sum  = f_int + n_int;
    fill_app  = FILL_W'(fill_sum);
    word_done = (fill_sum >= OUT_BYTES);
  end

  always_comb begin
    state_d    = state_q;
    prev_vld_d = align_lane_vld;
    n_d        = n_q;
    fill_d     = fill_q;
    acc_d      = acc_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    sof_pend_d = sof_pend_q;
    dat_d      = '0;
    be_d       = '0;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    cfg_err_d  = 1'b0;
    gap_err_d  = 1'b0;
    do_append  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (align_lane_vld && !prev_vld_q) begin
          n_d = lane_num;
          if (lane_legal) begin
            state_d    = ST_MERGE;
            sof_pend_d = 1'b1;
            do_append  = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
            state_d   = ST_DROP;
          end
        end
      end
      ST_MERGE: begin
        if (align_lane_vld) begin
          do_append = 1'b1;
        end else if (hold_vld_q) begin
          valid_d    = 1'b1;
          dat_d      = hold_q;
          be_d       = '1;
          sof_d      = sof_pend_q;
          sof_pend_d = 1'b0;
          hold_d     = '0;
          hold_vld_d = 1'b0;
          eof_d      = !has_partial;
          state_d    = has_partial ? ST_FLUSH : ST_IDLE;
        end else begin
          valid_d    = has_partial;
          dat_d      = has_partial ? acc_q : '0;
          be_d       = partial_be;
          sof_d      = has_partial & sof_pend_q;
          eof_d      = has_partial;
          sof_pend_d = 1'b0;
          acc_d      = '0;
          fill_d     = '0;
          state_d    = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        // Bytes arriving here have no slot; they are flagged and discarded.
        valid_d    = 1'b1;
        dat_d      = acc_q;
        be_d       = partial_be;
        sof_d      = sof_pend_q;
        eof_d      = 1'b1;
        sof_pend_d = 1'b0;
        acc_d      = '0;
        fill_d     = '0;
        gap_err_d  = align_lane_vld;
        state_d    = ST_IDLE;
      end
      ST_DROP: begin
        if (!align_lane_vld) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_append) begin
      if (word_done) begin
        if (hold_vld_q) begin
          valid_d    = 1'b1;
          dat_d      = hold_q;
          be_d       = '1;
          sof_d      = sof_pend_q;
          sof_pend_d = 1'b0;
        end
        hold_d     = acc_app;
        hold_vld_d = 1'b1;
        acc_d      = '0;
        fill_d     = '0;
      end else begin
        acc_d  = acc_app;
        fill_d = fill_app;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prev_vld_q <= 1'b1;
      n_q        <= '0;
      fill_q     <= '0;
      acc_q      <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      sof_pend_q <= 1'b0;
      dat_q      <= '0;
      be_q       <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      cfg_err_q  <= 1'b0;
      gap_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_vld_q <= prev_vld_d;
      n_q        <= n_d;
      fill_q     <= fill_d;
      acc_q      <= acc_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      sof_pend_q <= sof_pend_d;
      dat_q      <= dat_d;
      be_q       <= be_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      cfg_err_q  <= cfg_err_d;
      gap_err_q  <= gap_err_d;
    end
  end

  assign merging_dat   = dat_q;
  assign merging_be    = be_q;
  assign merging_valid = valid_q;
  assign pkt_sof       = sof_q;
  assign pkt_eof       = eof_q;
  assign cfg_err       = cfg_err_q;
  assign gap_err       = gap_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lane_merging_mx.sv
`default_nettype none
// Directed table-driven bench for lane_merging_mx (MAX_LANES=4, OUT_BYTES=4).
module tb_lane_merging_mx;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  lane_num;
  logic        align_lane_vld;
  logic [31:0] lane_data;
  logic [31:0] merging_dat;
  logic [3:0]  merging_be;
  logic        merging_valid;
  logic        pkt_sof;
  logic        pkt_eof;
  logic        cfg_err;
  logic        gap_err;

  int n_checks = 0;
  int n_fail   = 0;

  lane_merging_mx #(.MAX_LANES(4), .OUT_BYTES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .lane_num      (lane_num),
    .align_lane_vld(align_lane_vld),
    .lane_data     (lane_data),
    .merging_dat   (merging_dat),
    .merging_be    (merging_be),
    .merging_valid (merging_valid),
    .pkt_sof       (pkt_sof),
    .pkt_eof       (pkt_eof),
    .cfg_err       (cfg_err),
    .gap_err       (gap_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [2:0]  ln;
    logic [31:0] data;
    logic [40:0] exp;
  } vec_t;

  vec_t vecs[$];

  // {valid, sof, eof, cfg_err, gap_err, be[3:0], dat[31:0]}
  function automatic logic [40:0] w(input logic v, input logic s, input logic e,
                                    input logic c, input logic g,
                                    input logic [3:0] be, input logic [31:0] d);
    return {v, s, e, c, g, be, d};
  endfunction

  task automatic add(input logic vld, input logic [2:0] ln, input logic [31:0] data,
                     input logic [40:0] exp);
    vec_t v;
    v.vld = vld; v.ln = ln; v.data = data; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic step(input logic vld, input logic [2:0] ln, input logic [31:0] data);
    align_lane_vld = vld;
    lane_num       = ln;
    lane_data      = data;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [40:0] exp);
    logic [40:0] act;
    act = {merging_valid, pkt_sof, pkt_eof, cfg_err, gap_err, merging_be, merging_dat};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    reset          = 1'b1;
    align_lane_vld = 1'b0;
    lane_num       = 3'd0;
    lane_data      = '0;

    // Post-reset idle so the previous-sample register sees a low.
    add(1'b0, 3'd0, 32'h0, '0);
    // N=4, three words; lane_num changes mid-burst are ignored.
    add(1'b1, 3'd4, 32'h03020100, '0);
    add(1'b1, 3'd1, 32'h07060504, w(1, 1, 0, 0, 0, 4'hF, 32'h03020100));
    add(1'b1, 3'd2, 32'h0B0A0908, w(1, 0, 0, 0, 0, 4'hF, 32'h07060504));
    add(1'b0, 3'd4, 32'h0,        w(1, 0, 1, 0, 0, 4'hF, 32'h0B0A0908));
    add(1'b0, 3'd4, 32'h0, '0);
    // N=1, six bytes -> full word then a FLUSH partial.
    add(1'b1, 3'd1, 32'hEEEEEE11, '0);
    add(1'b1, 3'd1, 32'hEEEEEE12, '0);
    add(1'b1, 3'd1, 32'hEEEEEE13, '0);
    add(1'b1, 3'd1, 32'hEEEEEE14, '0);
    add(1'b1, 3'd1, 32'hEEEEEE15, '0);
    add(1'b1, 3'd1, 32'hEEEEEE16, '0);
    add(1'b0, 3'd1, 32'h0, w(1, 1, 0, 0, 0, 4'hF, 32'h14131211));
    add(1'b0, 3'd1, 32'h0, w(1, 0, 1, 0, 0, 4'h3, 32'h00001615));
    add(1'b0, 3'd1, 32'h0, '0);
    // N=2 single cycle: one partial word, sof and eof together.
    add(1'b1, 3'd2, 32'hEEEEBBAA, '0);
    add(1'b0, 3'd2, 32'h0, w(1, 1, 1, 0, 0, 4'h3, 32'h0000BBAA));
    add(1'b0, 3'd2, 32'h0, '0);
    // Illegal lane count drops the burst, next burst merges.
    add(1'b1, 3'd3, 32'h12345678, w(0, 0, 0, 1, 0, 4'h0, 32'h0));
    add(1'b1, 3'd2, 32'h9ABCDEF0, '0);
    add(1'b1, 3'd2, 32'h11223344, '0);
    add(1'b0, 3'd2, 32'h0, '0);
    add(1'b1, 3'd2, 32'hEEEE3231, '0);
    add(1'b1, 3'd2, 32'hEEEE3433, '0);
    add(1'b0, 3'd2, 32'h0, w(1, 1, 1, 0, 0, 4'hF, 32'h34333231));
    add(1'b0, 3'd2, 32'h0, '0);
    // Valid re-asserted in FLUSH: gap_err, bytes lost, no burst until low.
    add(1'b1, 3'd2, 32'hEEEE4241, '0);
    add(1'b1, 3'd2, 32'hEEEE4443, '0);
    add(1'b1, 3'd2, 32'hEEEE4645, '0);
    add(1'b0, 3'd2, 32'h0,        w(1, 1, 0, 0, 0, 4'hF, 32'h44434241));
    add(1'b1, 3'd2, 32'hEEEE7877, w(1, 0, 1, 0, 1, 4'h3, 32'h00004645));
    add(1'b1, 3'd2, 32'hEEEE7A79, '0);
    add(1'b0, 3'd2, 32'h0, '0);
    add(1'b1, 3'd4, 32'h53525150, '0);
    add(1'b0, 3'd4, 32'h0, w(1, 1, 1, 0, 0, 4'hF, 32'h53525150));
    add(1'b0, 3'd4, 32'h0, '0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", '0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].vld, vecs[i].ln, vecs[i].data);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset mid-burst, valid held high across release.
    step(1'b1, 3'd4, 32'hA3A2A1A0);
    check("rst_pre0", '0);
    step(1'b1, 3'd4, 32'hB3B2B1B0);
    check("rst_pre1", w(1, 1, 0, 0, 0, 4'hF, 32'hA3A2A1A0));
    reset = 1'b1;
    step(1'b1, 3'd4, 32'hC3C2C1C0);
    check("rst_mid", '0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 3'd4, 32'hC3C2C1C0 + 32'(k));
      check($sformatf("rst_held%0d", k), '0);
    end
    step(1'b0, 3'd4, 32'h0);
    check("rst_drop", '0);
    step(1'b1, 3'd4, 32'hD3D2D1D0);
    check("rst_new0", '0);
    step(1'b0, 3'd4, 32'h0);
    check("rst_new1", w(1, 1, 1, 0, 0, 4'hF, 32'hD3D2D1D0));
    step(1'b0, 3'd4, 32'h0);
    check("rst_new2", '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lane_merging_mx.md
# lane_merging_mx

Parametrised successor to the CSI-2 lane merger. It sits between per-lane deskew/alignment and the packet parser. It accepts 1, 2 or 4 aligned byte lanes and packs the byte stream into OUT_BYTES-wide words, with packet start/end marking, partial-last-word byte enables and configuration/protocol error flags. A one-word hold stage lets the last word of every burst carry pkt_eof.

## Interface
Parameters:
- MAX_LANES, 4, number of physical lanes instantiated; legal values 1, 2, 4.
- OUT_BYTES, 4, output word width in bytes; a power of two and ≥ MAX_LANES.

Ports:
- clk  input  1  clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- lane_num  input  3  active lane count; legal values 1, 2, 4, and ≤ MAX_LANES.
- align_lane_vld  input  1  aligned lane data valid; high for the whole burst.
- lane_data  input  8*MAX_LANES  lane i byte at [8i+7:8i].
- merging_dat  output  8*OUT_BYTES  packed word; first byte of the word at [7:0].
- merging_be  output  OUT_BYTES  byte enables; bit b qualifies byte b.
- merging_valid  output  1  word valid, one-cycle qualifier.
- pkt_sof  output  1  first word of a burst; valid only with merging_valid.
- pkt_eof  output  1  last word of a burst; valid only with merging_valid.
- cfg_err  output  1  one-cycle pulse: illegal lane_num at burst start.
- gap_err  output  1  one-cycle pulse: align_lane_vld high during FLUSH.

## Operation
- Byte order within a cycle: lane0, lane1, …, lane(N-1), where N is the latched lane count. Bytes fill the accumulator from byte 0 upward.
- States are IDLE, MERGE, FLUSH and DROP.
- IDLE:
  - A burst starts when align_lane_vld=1 and its previous sample is 0. Reset sets the previous-sample register to 1, so a burst already in progress at reset release is ignored until align_lane_vld goes low.
  - At burst start, lane_num is latched as N.
  - If N is legal: go to MERGE and process that cycle's bytes.
  - If N is illegal: pulse cfg_err and go to DROP.
- MERGE, align_lane_vld=1:
  - Append N bytes; fill += N.
  - When fill reaches OUT_BYTES, the completed word moves to the hold register and fill becomes 0.
  - If the hold register was already occupied, its old word is emitted: merging_valid=1, merging_be all ones, pkt_eof=0.
  - lane_num changes during MERGE are ignored.
- MERGE, align_lane_vld=0 (end of burst):
  - hold set, fill=0: emit hold with pkt_eof=1; go to IDLE.
  - hold set, fill>0: emit hold with pkt_eof=0; go to FLUSH.
  - hold empty, fill>0: emit the partial word with pkt_eof=1; go to IDLE.
- FLUSH (one cycle):
  - Emit the partial word with pkt_eof=1 and merging_be[fill-1:0]=1, upper enable bits 0.
  - Go to IDLE.
  - If align_lane_vld=1 in FLUSH, those bytes are dropped and gap_err pulses. Because the previous sample is 1, no burst starts until align_lane_vld goes low.
- DROP: discard all input and produce no output; go to IDLE when align_lane_vld=0.
- pkt_sof is 1 on the first emitted word of each burst, including a single-word burst, where pkt_sof=pkt_eof=1.
- Unused bytes of a partial word are 0. merging_dat and merging_be are 0 whenever merging_valid=0.
- Because N divides OUT_BYTES, fill never overshoots and no byte is split across words.

## Timing
- All outputs are registered. Reset value of every output is 0; fill, hold and state are cleared; state is IDLE.
- A word completed at edge k is emitted at the edge of the next word completion, or at the end-detect edge if the burst ends first. It is visible in the cycle after that edge.
- Example, N=4, OUT_BYTES=4, 3-cycle burst:
  - Words complete at edges 0, 1, 2.
  - W0 is emitted at edge 1 with pkt_sof.
  - W1 is emitted at edge 2.
  - W2 is emitted at edge 3 (align_lane_vld low sampled) with pkt_eof.
- At most one word is emitted per cycle. Throughput equals the input rate.
- Minimum idle gap between bursts: 1 cycle, or 2 cycles if the burst ends with fill>0 and hold set (the FLUSH case).
- Reset asserted mid-burst: the next edge clears everything. No partial or EOF word is emitted for the interrupted burst.

## Test plan
- N=4, OUT_BYTES=4: 3 cycles of bytes 00..0B -> words 0x03020100 (sof), 0x07060504, 0x0B0A0908 (eof); merging_be=0xF for all three.
- N=1: 6 cycles of bytes 11..16 -> 0x14131211 (sof, be=F), then after FLUSH 0x00001615 (eof, be=0x3).
- N=2: a single cycle of AA,BB -> one word 0x0000BBAA with sof=eof=1 and be=0x3; no FLUSH occurs.
- lane_num=3 at burst start -> cfg_err for 1 cycle, no merging_valid for the whole burst. The next burst with lane_num=2 merges normally.
- Protocol and reset cases:
  - align_lane_vld re-asserted in the FLUSH cycle -> gap_err pulses and those bytes are lost.
  - Reset asserted mid-burst -> all outputs 0.
  - align_lane_vld held high across reset release -> ignored until it drops.
